// File: rtl/edge_latch_bank_pkg.sv
// Shared definitions for the edge latch bank: edge-mode encodings and filter sizing.
package edge_latch_bank_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    function automatic int filt_cnt_width(input int filter_cycles);
        return (filter_cycles < 1) ? 1 : $clog2(filter_cycles + 1);
    endfunction

    function automatic logic edge_hit(input logic [1:0] mode, input logic rise, input logic fall);
        logic hit;
        case (mode)
            EDGE_OFF:  hit = 1'b0;
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_filter_chan.sv
// One channel: reclocking chain, consecutive-sample glitch filter and edge detector.
module edge_filter_chan
    import edge_latch_bank_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    localparam int              CW       = filt_cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   level_prev_q, level_prev_d;
    logic                   synced_s;

    assign synced_s = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], din};
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        if (synced_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced_s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
        end
    end

    assign rise = level_q & ~level_prev_q;
    assign fall = ~level_q & level_prev_q;

endmodule

// File: rtl/edge_latch_bank.sv
// Bank of filtered, edge-programmable event latches with overrun tracking,
// masked interrupt and atomic snapshot-and-clear.
module edge_latch_bank
    import edge_latch_bank_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic               masterClk,
    input  logic               resetN,
    input  logic [WIDTH-1:0]   latchInput,
    input  logic [2*WIDTH-1:0] edgeSel,
    input  logic [WIDTH-1:0]   irqMask,
    input  logic [WIDTH-1:0]   clearMask,
    input  logic               clearStrobe,
    input  logic               snapStrobe,
    output logic [WIDTH-1:0]   latchOutput,
    output logic [WIDTH-1:0]   overrun,
    output logic [WIDTH-1:0]   snapData,
    output logic [WIDTH-1:0]   snapOverrun,
    output logic               snapValid,
    output logic               irq
);

    logic [WIDTH-1:0] rise_s, fall_s, edge_s, clr_s;
    logic [WIDTH-1:0] lat_q, lat_d, ovr_q, ovr_d;
    logic [WIDTH-1:0] snap_data_q, snap_data_d, snap_ovr_q, snap_ovr_d;
    logic             snap_valid_q, snap_valid_d, irq_q, irq_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_filter_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clk   (masterClk),
            .rst_n (resetN),
            .din   (latchInput[i]),
            .rise  (rise_s[i]),
            .fall  (fall_s[i])
        );
    end

    // An edge always wins over a clear so no event is lost; snapStrobe overrides clearMask.
    always_comb begin
        clr_s = snapStrobe ? {WIDTH{1'b1}} : (clearStrobe ? clearMask : {WIDTH{1'b0}});
        for (int i = 0; i < WIDTH; i++) begin
            edge_s[i] = edge_hit(edgeSel[2*i +: 2], rise_s[i], fall_s[i]);
            if (edge_s[i]) begin
                lat_d[i] = 1'b1;
                ovr_d[i] = clr_s[i] ? 1'b0 : (ovr_q[i] | lat_q[i]);
            end else if (clr_s[i]) begin
                lat_d[i] = 1'b0;
                ovr_d[i] = 1'b0;
            end else begin
                lat_d[i] = lat_q[i];
                ovr_d[i] = ovr_q[i];
            end
        end
        if (snapStrobe) begin
            snap_data_d = lat_q;
            snap_ovr_d  = ovr_q;
        end else begin
            snap_data_d = snap_data_q;
            snap_ovr_d  = snap_ovr_q;
        end
        snap_valid_d = snapStrobe;
        irq_d        = |(lat_q & irqMask);
    end

    // Latch, snapshot and interrupt registers.
    always_ff @(posedge masterClk or negedge resetN) begin
        if (!resetN) begin
            lat_q        <= '0;
            ovr_q        <= '0;
            snap_data_q  <= '0;
            snap_ovr_q   <= '0;
            snap_valid_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            lat_q        <= lat_d;
            ovr_q        <= ovr_d;
            snap_data_q  <= snap_data_d;
            snap_ovr_q   <= snap_ovr_d;
            snap_valid_q <= snap_valid_d;
            irq_q        <= irq_d;
        end
    end

    assign latchOutput = lat_q;
    assign overrun     = ovr_q;
    assign snapData    = snap_data_q;
    assign snapOverrun = snap_ovr_q;
    assign snapValid   = snap_valid_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_edge_latch_bank.sv
// Self-checking bench for edge_latch_bank: directed vectors, corner sequences
// and randomized traffic compared against a window-based reference model.
module tb_edge_latch_bank;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int FC = 3;

    logic           masterClk = 1'b0;
    logic           resetN;
    logic [W-1:0]   latchInput, irqMask, clearMask;
    logic [2*W-1:0] edgeSel;
    logic           clearStrobe, snapStrobe;
    logic [W-1:0]   latchOutput, overrun, snapData, snapOverrun;
    logic           snapValid, irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 masterClk = ~masterClk;

    edge_latch_bank #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(FC)) dut (
        .masterClk   (masterClk),
        .resetN      (resetN),
        .latchInput  (latchInput),
        .edgeSel     (edgeSel),
        .irqMask     (irqMask),
        .clearMask   (clearMask),
        .clearStrobe (clearStrobe),
        .snapStrobe  (snapStrobe),
        .latchOutput (latchOutput),
        .overrun     (overrun),
        .snapData    (snapData),
        .snapOverrun (snapOverrun),
        .snapValid   (snapValid),
        .irq         (irq)
    );

    // Reference model: input samples since reset, filtered level = value of the
    // last FC reclocked samples when they all agree.
    logic [W-1:0] samp_q[$];
    int           k;
    logic [W-1:0] m_filt, m_filt_prev, m_lat, m_ovr, m_sd, m_so;
    logic         m_sv, m_irq;

    task automatic model_reset();
        samp_q.delete();
        k = 0;
        m_filt = '0; m_filt_prev = '0; m_lat = '0; m_ovr = '0; m_sd = '0; m_so = '0;
        m_sv = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [W-1:0] syn_at(input int j);
        int i;
        i = j - S + 1;
        if (i < 1) return '0;
        return samp_q[i-1];
    endfunction

    task automatic model_step();
        logic [W-1:0] nf, rise, fall, ev, clr, s;
        int ones;
        k++;
        samp_q.push_back(latchInput);
        nf = m_filt;
        for (int b = 0; b < W; b++) begin
            ones = 0;
            for (int t = 1; t <= FC; t++) begin
                s = syn_at(k - t);
                ones += int'(s[b]);
            end
            if (ones == FC) nf[b] = 1'b1;
            else if (ones == 0) nf[b] = 1'b0;
        end
        rise = m_filt & ~m_filt_prev;
        fall = ~m_filt & m_filt_prev;
        for (int b = 0; b < W; b++)
            ev[b] = (rise[b] & edgeSel[2*b]) | (fall[b] & edgeSel[2*b+1]);
        clr = snapStrobe ? {W{1'b1}} : (clearStrobe ? clearMask : {W{1'b0}});
        m_irq = |(m_lat & irqMask);
        if (snapStrobe) begin
            m_sd = m_lat;
            m_so = m_ovr;
        end
        m_sv = snapStrobe;
        m_ovr = (m_ovr | (ev & m_lat)) & ~clr;
        m_lat = ev | (m_lat & ~clr);
        m_filt_prev = m_filt;
        m_filt = nf;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model at the edge, compare everything on the falling edge.
    task automatic tick();
        @(posedge masterClk);
        if (resetN) model_step();
        @(negedge masterClk);
        n_tests++;
        if ({latchOutput, overrun, snapData, snapOverrun, snapValid, irq} !==
            {m_lat, m_ovr, m_sd, m_so, m_sv, m_irq}) begin
            n_fail++;
            $display("FAIL model t=%0t: lat %h/%h ovr %h/%h sd %h/%h so %h/%h sv %b/%b irq %b/%b",
                     $time, latchOutput, m_lat, overrun, m_ovr, snapData, m_sd,
                     snapOverrun, m_so, snapValid, m_sv, irq, m_irq);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        latchInput = '0; clearStrobe = 1'b0; snapStrobe = 1'b0; clearMask = '0;
        model_reset();
        repeat (2) tick();
        resetN = 1'b1;
    endtask

    typedef struct {
        logic [1:0] mode;
        int         len;
        logic       exp_lat;
        logic       exp_ovr;
    } vec_t;
    vec_t vecs[8];

    initial begin
        vecs[0] = '{2'b01, 2,  1'b0, 1'b0};
        vecs[1] = '{2'b01, 3,  1'b1, 1'b0};
        vecs[2] = '{2'b10, 3,  1'b1, 1'b0};
        vecs[3] = '{2'b11, 3,  1'b1, 1'b1};
        vecs[4] = '{2'b11, 2,  1'b0, 1'b0};
        vecs[5] = '{2'b00, 10, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 1,  1'b0, 1'b0};
        vecs[7] = '{2'b11, 10, 1'b1, 1'b1};

        // Input held high through reset gives a rising edge after release.
        resetN = 1'b1;
        latchInput = {W{1'b1}}; edgeSel = {W{2'b01}}; irqMask = 8'h01;
        clearMask = '0; clearStrobe = 1'b0; snapStrobe = 1'b0;
        model_reset();
        #1 resetN = 1'b0;
        repeat (2) tick();
        resetN = 1'b1;
        repeat (5) tick();
        check("rst_lat_early", 32'(latchOutput), 32'h00);
        tick();
        check("rst_lat6", 32'(latchOutput), 32'hFF);
        check("rst_ovr", 32'(overrun), 32'h00);
        check("rst_irq_early", 32'(irq), 32'h0);
        tick();
        check("rst_irq7", 32'(irq), 32'h1);

        // Table: single pulse on bit 0 under each edge mode.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            edgeSel = {{(W-1){2'b00}}, vecs[v].mode};
            repeat (3) tick();
            latchInput[0] = 1'b1;
            repeat (vecs[v].len) tick();
            latchInput[0] = 1'b0;
            repeat (14) tick();
            check($sformatf("vec%0d_lat", v), 32'(latchOutput[0]), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_ovr", v), 32'(overrun[0]), 32'(vecs[v].exp_ovr));
        end

        // Exact filter latency for a 3-cycle pulse.
        do_reset();
        edgeSel = {W{2'b01}};
        repeat (3) tick();
        latchInput[0] = 1'b1;
        repeat (3) tick();
        latchInput[0] = 1'b0;
        repeat (2) tick();
        check("filt_lat5", 32'(latchOutput[0]), 32'h0);
        tick();
        check("filt_lat6", 32'(latchOutput[0]), 32'h1);

        // Overrun on bit 4 then masked clear.
        do_reset();
        edgeSel = {W{2'b01}};
        latchInput = 8'h14; repeat (4) tick();
        latchInput = 8'h00; repeat (4) tick();
        latchInput = 8'h10; repeat (4) tick();
        latchInput = 8'h00; repeat (10) tick();
        check("ovr_lat", 32'(latchOutput), 32'h14);
        check("ovr_ovr", 32'(overrun), 32'h10);
        clearStrobe = 1'b1; clearMask = 8'h10;
        tick();
        clearStrobe = 1'b0; clearMask = 8'h00;
        check("clr_lat", 32'(latchOutput), 32'h04);
        check("clr_ovr", 32'(overrun), 32'h00);

        // Snapshot coincident with a bit-0 edge.
        do_reset();
        edgeSel = {W{2'b01}};
        latchInput = 8'h05; repeat (4) tick();
        latchInput = 8'h00; repeat (10) tick();
        check("snap_pre", 32'(latchOutput), 32'h05);
        latchInput = 8'h01;
        repeat (5) tick();
        snapStrobe = 1'b1;
        tick();
        snapStrobe = 1'b0;
        check("snap_data", 32'(snapData), 32'h05);
        check("snap_valid", 32'(snapValid), 32'h1);
        check("snap_lat", 32'(latchOutput), 32'h01);
        check("snap_ovr", 32'(overrun), 32'h00);
        check("snap_sovr", 32'(snapOverrun), 32'h00);
        tick();
        check("snap_valid_drop", 32'(snapValid), 32'h0);
        check("snap_hold", 32'(snapData), 32'h05);

        // Asynchronous reset pulse mid-filter.
        irqMask = 8'hFF;
        tick();
        latchInput = 8'h20;
        repeat (3) tick();
        latchInput = 8'h00;
        #2 resetN = 1'b0;
        #1 check("areset_outs", 32'({latchOutput, overrun, snapData, snapOverrun, snapValid, irq}), 32'h0);
        resetN = 1'b1;
        model_reset();
        repeat (12) tick();
        check("areset_nolatch", 32'(latchOutput), 32'h00);

        // Randomized traffic against the model.
        do_reset();
        edgeSel = 16'($urandom);
        irqMask = W'($urandom);
        for (int c = 0; c < 1500; c++) begin
            latchInput  = latchInput ^ (W'($urandom) & W'($urandom));
            if ($urandom_range(0, 15) == 0) edgeSel = 16'($urandom);
            if ($urandom_range(0, 15) == 0) irqMask = W'($urandom);
            clearStrobe = ($urandom_range(0, 7) == 0);
            clearMask   = W'($urandom);
            snapStrobe  = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
